// File: rtl/writeback_regfile.sv
// writeback_regfile: Y86-64 register file with decode, writeback and sticky status.
module writeback_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vflag,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        cnd,
    input  logic        imem_error,
    input  logic        dmem_error,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [1:0]  stat,
    output logic        halted
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [1:0] AOK = 2'b00, HLT = 2'b01, ADR = 2'b10, INS = 2'b11;

    logic [63:0] regs [0:14];
    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [1:0]  nxt_stat;

    always_comb begin
        src_a = (icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? rA :
                (icode inside {4'h9, 4'hB}) ? RSP : RNONE;
        src_b = (icode inside {4'h4, 4'h5, 4'h6}) ? rB :
                (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : RNONE;
        dst_e = (icode == 4'h2) ? (cnd ? rB : RNONE) :
                (icode inside {4'h3, 4'h6}) ? rB :
                (icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP : RNONE;
        dst_m = (icode inside {4'h5, 4'hB}) ? rA : RNONE;
        nxt_stat = (imem_error || dmem_error) ? ADR :
                   (icode > 4'hB) ? INS :
                   (icode == 4'h0) ? HLT : AOK;
    end

    assign valA   = (src_a == RNONE) ? '0 : regs[src_a];
    assign valB   = (src_b == RNONE) ? '0 : regs[src_b];
    assign halted = (stat != AOK);

    // dstM is assigned after dstE so valM wins when both name the same register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) regs[i] <= '0;
            stat <= AOK;
        end else if (vflag && stat == AOK) begin
            stat <= nxt_stat;
            if (nxt_stat == AOK) begin
                if (dst_e != RNONE) regs[dst_e] <= valE;
                if (dst_m != RNONE) regs[dst_m] <= valM;
            end
        end
    end
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed checks of decode, writeback, status and async reset.
module tb_writeback_regfile;
    logic        clk = 0, rst_n = 0, vflag = 0, cnd = 0, imem_error = 0, dmem_error = 0;
    logic [3:0]  icode = 0, rA = 4'hF, rB = 4'hF;
    logic [63:0] valE = 0, valM = 0, valA, valB;
    logic [1:0]  stat;
    logic        halted;
    int          errors = 0, checks = 0;

    writeback_regfile dut (
        .clk(clk), .rst_n(rst_n), .vflag(vflag), .icode(icode), .rA(rA), .rB(rB),
        .valE(valE), .valM(valM), .cnd(cnd), .imem_error(imem_error),
        .dmem_error(dmem_error), .valA(valA), .valB(valB), .stat(stat), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one valid instruction across a rising edge, sampled 1 time unit after it
    task automatic exec(input logic [3:0] ic, a, b, input logic [63:0] e, m, input logic c);
        icode = ic; rA = a; rB = b; valE = e; valM = m; cnd = c; vflag = 1;
        @(posedge clk); #1;
        vflag = 0; imem_error = 0; dmem_error = 0; cnd = 0;
    endtask

    // read a register through both read ports using OPq decode with vflag low
    task automatic rd(input string tag, input logic [3:0] r, input logic [63:0] exp);
        vflag = 0; icode = 4'h6; rA = r; rB = r; #1;
        check({tag, ".A"}, valA, exp);
        check({tag, ".B"}, valB, exp);
    endtask

    task automatic do_reset;
        rst_n = 0; #2; rst_n = 1; #1;
    endtask

    initial begin
        #3;
        check("rst_stat", {62'd0, stat}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        rst_n = 1;
        @(posedge clk); #1;
        rd("rst_reg2", 4'd2, 64'd0);

        exec(4'h3, 4'hF, 4'd2, 64'h1234, 64'h0, 1'b0);
        rd("irmovq_reg2", 4'd2, 64'h1234);

        icode = 4'h1; rA = 4'd2; rB = 4'd2; #1;
        check("nop_valA_rnone", valA, 64'd0);
        check("nop_valB_rnone", valB, 64'd0);

        exec(4'h2, 4'hF, 4'd3, 64'd5, 64'd0, 1'b0);
        rd("cmov_cnd0", 4'd3, 64'd0);
        exec(4'h2, 4'hF, 4'd3, 64'd5, 64'd0, 1'b1);
        rd("cmov_cnd1", 4'd3, 64'd5);

        exec(4'h3, 4'hF, 4'd4, 64'h100, 64'h0, 1'b0);
        rd("rsp_init", 4'd4, 64'h100);
        icode = 4'hA; rA = 4'd2; rB = 4'hF; #1;
        check("pushq_srcA", valA, 64'h1234);
        check("pushq_srcB_rsp", valB, 64'h100);
        exec(4'hB, 4'd4, 4'hF, 64'h108, 64'hABC, 1'b0);
        rd("popq_rsp", 4'd4, 64'hABC);

        // write not visible on the ports until after the edge
        icode = 4'h3; rB = 4'd7; valE = 64'h55; vflag = 1; rA = 4'hF;
        @(negedge clk);
        icode = 4'h6; rA = 4'd7; #1;
        check("no_bypass", valA, 64'd0);
        icode = 4'h3; #1;
        @(posedge clk); #1; vflag = 0;
        rd("after_edge_reg7", 4'd7, 64'h55);

        exec(4'h5, 4'd1, 4'hF, 64'h0, 64'h11, 1'b0);
        rd("mrmovq_reg1", 4'd1, 64'h11);
        dmem_error = 1;
        exec(4'h5, 4'd1, 4'hF, 64'h0, 64'h99, 1'b0);
        check("adr_stat", {62'd0, stat}, 64'd2);
        check("adr_halted", {63'd0, halted}, 64'd1);
        rd("adr_reg1_kept", 4'd1, 64'h11);
        exec(4'h3, 4'hF, 4'd1, 64'h77, 64'h0, 1'b0);
        rd("adr_irmovq_blocked", 4'd1, 64'h11);
        exec(4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
        check("adr_sticky", {62'd0, stat}, 64'd2);

        do_reset;
        check("reset_clears_adr", {62'd0, stat}, 64'd0);
        rd("reset_clears_reg1", 4'd1, 64'd0);
        exec(4'hD, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
        check("ins_stat", {62'd0, stat}, 64'd3);

        do_reset;
        imem_error = 1;
        exec(4'hE, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
        check("adr_over_ins", {62'd0, stat}, 64'd2);

        do_reset;
        exec(4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0);
        check("hlt_stat", {62'd0, stat}, 64'd1);
        check("hlt_halted", {63'd0, halted}, 64'd1);
        exec(4'h3, 4'hF, 4'd6, 64'd9, 64'h0, 1'b0);
        rd("hlt_write_ignored", 4'd6, 64'd0);

        do_reset;
        icode = 4'hF; vflag = 0;
        @(posedge clk); #1;
        check("invalid_no_status", {62'd0, stat}, 64'd0);

        exec(4'h3, 4'hF, 4'd5, 64'd7, 64'h0, 1'b0);
        rd("reg5_set", 4'd5, 64'd7);
        rst_n = 0; #1;
        rd("async_reg5", 4'd5, 64'd0);
        check("async_stat", {62'd0, stat}, 64'd0);
        exec(4'h3, 4'hF, 4'd5, 64'd7, 64'h0, 1'b0);
        rd("no_write_in_reset", 4'd5, 64'd0);
        rst_n = 1;
        exec(4'h3, 4'hF, 4'd5, 64'h42, 64'h0, 1'b0);
        rd("resume_after_reset", 4'd5, 64'h42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; the ports are listed below, clock and reset first.
REQ-002 clk  input  1  rising-edge clock; all register-file writes and status updates occur on this edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 vflag  input  1  instruction valid; while low, no write and no status update occur.
REQ-005 icode  input  4  Y86-64 instruction code of the current instruction.
REQ-006 rA  input  4  register specifier A (0x0-0xE are registers; 0xF is RNONE).
REQ-007 rB  input  4  register specifier B (same encoding as rA).
REQ-008 valE  input  64  execute-stage result.
REQ-009 valM  input  64  memory-stage read data.
REQ-010 cnd  input  1  execute-stage condition flag; gates the cmovXX writeback.
REQ-011 imem_error  input  1  fetch address error for the current instruction.
REQ-012 dmem_error  input  1  data memory address error for the current instruction.
REQ-013 valA  output  64  operand read from srcA; combinational; 0 when srcA = RNONE.
REQ-014 valB  output  64  operand read from srcB; combinational; 0 when srcB = RNONE.
REQ-015 stat  output  2  processor status: 00 AOK, 01 HLT, 10 ADR, 11 INS.
REQ-016 halted  output  1  high whenever stat != AOK.

Function
REQ-017 Storage SHALL be 15 x 64-bit registers, indices 0-14; index 4 is %rsp.
REQ-018 srcA decode: icode 2/4/6/A selects rA; icode 9/B selects 4; all other icodes select RNONE.
REQ-019 srcB decode: icode 4/5/6 selects rB; icode 8/9/A/B selects 4; all other icodes select RNONE.
REQ-020 dstE decode: icode 2 selects rB if cnd=1, otherwise RNONE; icode 3/6 selects rB; icode 8/9/A/B selects 4; all other icodes select RNONE.
REQ-021 dstM decode: icode 5/B selects rA; all other icodes select RNONE.
REQ-022 Write enable on a rising edge SHALL require vflag=1, stat=AOK, and no new exception condition raised by the current instruction.
REQ-023 When write is enabled, the block SHALL write valE to dstE and valM to dstM on the same edge; a destination of RNONE is never written.
REQ-024 When dstE = dstM, valM SHALL win (popq %rsp leaves %rsp = valM).
REQ-025 Reads SHALL be combinational from the current contents; a write on an edge is visible only after that edge, with no bypass.
REQ-026 Status priority on a valid instruction: imem_error or dmem_error sets ADR; otherwise icode > 0xB sets INS; otherwise icode 0 sets HLT; otherwise stat stays AOK.
REQ-027 stat SHALL be sticky: once it leaves AOK, it holds until reset and ignores all further inputs.
REQ-028 An instruction that raises ADR, INS or HLT SHALL perform no register write.
REQ-029 Operand reads SHALL stay functional while halted, so a bench can inspect state.

Reset
REQ-030 When rst_n goes low, all 15 registers SHALL clear to 0 and stat SHALL clear to AOK immediately, without waiting for a clock edge.
REQ-031 While rst_n is low, no write SHALL occur, even when vflag=1.
REQ-032 Reset deasserted mid-program SHALL resume with cleared state on the first rising edge after deassertion.

Verification
REQ-033 irmovq: icode=3, rB=2, valE=0x1234, vflag=1, one edge -> reg2 = 0x1234; srcB of a following icode=6 with rB=2 gives valB = 0x1234.
REQ-034 cmov: icode=2, rB=3, valE=5, cnd=0 -> reg3 unchanged (0); repeat with cnd=1 -> reg3 = 5.
REQ-035 popq %rsp: reg4 = 0x100; apply icode=B, rA=4, valE=0x108, valM=0xABC -> reg4 = 0xABC.
REQ-036 Exceptions: dmem_error=1 on mrmovq (icode=5, rA=1) -> stat=10, reg1 unchanged; a later valid irmovq does not write; icode=0xD after reset -> stat=11.
REQ-037 Halt: icode=0, vflag=1 -> stat=01 and halted=1; a later icode=3 write is ignored; vflag=0 with icode=0xF after reset leaves stat=00.
REQ-038 Async reset: with reg5 = 7, pull rst_n low between edges -> reg5 reads 0 and stat = 00 before the next edge.
